// File: rtl/bss_pkg.sv
// Shared types and helpers for the bit-serial subtractor and related serial arithmetic blocks.
package bss_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } bss_state_t;

    // Bit-index counter width: one extra bit so the counter can hold WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/bit_full_sub.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module bit_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = A - B, one bit per clock, LSB first,
// with a load/start/done handshake and a final borrow flag for unsigned compare.
module bit_serial_subtractor
    import bss_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    bss_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bin;
    logic             r_borrow;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_a_sh;
    logic [WIDTH-1:0] w_b_sh;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_d;
    logic             w_bout;

    // Operands stay put; the current bit is selected by shifting a copy down.
    assign w_a_sh = r_a >> r_cnt;
    assign w_b_sh = r_b >> r_cnt;
    assign w_mask = {{(WIDTH-1){1'b0}}, 1'b1} << r_cnt;
    assign w_diff_next = (r_diff & ~w_mask) | (w_d ? w_mask : '0);

    bit_full_sub u_cell (
        .a    (w_a_sh[0]),
        .b    (w_b_sh[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (load) begin
                        r_a      <= A;
                        r_b      <= B;
                        r_diff   <= '0;
                        r_borrow <= 1'b0;
                        r_zero   <= 1'b0;
                        r_done   <= 1'b0;
                        r_state  <= IDLE;
                    end else if (start) begin
                        r_state <= SUB;
                        r_cnt   <= '0;
                        r_bin   <= 1'b0;
                        r_diff  <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                SUB: begin
                    r_diff <= w_diff_next;
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_IDX) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_borrow <= w_bout;
                        r_zero   <= (w_diff_next == '0);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;
    assign zero   = r_zero;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed-vector bench for bit_serial_subtractor at WIDTH=4 and WIDTH=8.
module tb_bit_serial_subtractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       load4, start4;
    logic [3:0] a4, b4, diff4;
    logic       borrow4, zero4, busy4, done4;

    logic       load8, start8;
    logic [7:0] a8, b8, diff8;
    logic       borrow8, zero8, busy8, done8;

    int n_checks = 0;
    int n_fail   = 0;

    bit_serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .load(load4), .start(start4), .A(a4), .B(b4),
        .diff(diff4), .borrow(borrow4), .zero(zero4), .busy(busy4), .done(done4)
    );

    bit_serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .load(load8), .start(start8), .A(a8), .B(b8),
        .diff(diff8), .borrow(borrow8), .zero(zero8), .busy(busy8), .done(done8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op4(input logic [3:0] a, input logic [3:0] b);
        a4 = a; b4 = b; load4 = 1'b1;
        tick();
        load4 = 1'b0;
    endtask

    // Raise start, hold it for 'hold' edges, and count edges until done (bounded).
    task automatic run4(input int hold, output int cycles, output int busy_cnt, output int done_low);
        cycles = 0; busy_cnt = 0; done_low = 0;
        start4 = 1'b1;
        while (cycles < 20) begin
            tick();
            cycles++;
            if (cycles >= hold) start4 = 1'b0;
            if (busy4) busy_cnt++;
            if (!done4) done_low++;
            if (done4) break;
        end
        start4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load4 = 0; start4 = 0; a4 = '0; b4 = '0;
        load8 = 0; start8 = 0; a8 = '0; b8 = '0;
        repeat (3) tick();
        n_checks++;
        if ({diff4, borrow4, zero4, busy4, done4} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset4: got diff=%0d b=%b z=%b busy=%b done=%b, expected all 0",
                     diff4, borrow4, zero4, busy4, done4);
        end
        n_checks++;
        if ({diff8, borrow8, zero8, busy8, done8} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset8: got diff=%0d b=%b z=%b busy=%b done=%b, expected all 0",
                     diff8, borrow8, zero8, busy8, done8);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int cyc, bc, dl;
        load_op4(4'd13, 4'd11);
        run4(4, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || done4 !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d edges done=%b, expected 5 edges done=1", cyc, done4);
        end
        n_checks++;
        if ({diff4, borrow4, zero4} !== {4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_13_11: got diff=%0d b=%b z=%b, expected diff=2 b=0 z=0", diff4, borrow4, zero4);
        end
        tick();
        n_checks++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL done_hold: got done=%b busy=%b, expected done=1 busy=0", done4, busy4);
        end
    endtask

    task automatic test_borrow();
        int cyc, bc, dl;
        load_op4(4'd11, 4'd13);
        n_checks++;
        if (done4 !== 1'b0 || diff4 !== 4'd0) begin
            n_fail++;
            $display("FAIL load_clears: got done=%b diff=%0d, expected done=0 diff=0", done4, diff4);
        end
        run4(1, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || {diff4, borrow4, zero4} !== {4'd14, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL borrow_11_13: got %0d edges diff=%0d b=%b z=%b, expected 5 edges diff=14 b=1 z=0",
                     cyc, diff4, borrow4, zero4);
        end
    endtask

    task automatic test_zero_rerun();
        int cyc, bc, dl;
        load_op4(4'd5, 4'd5);
        run4(1, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || {diff4, borrow4, zero4} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL zero_5_5: got %0d edges diff=%0d b=%b z=%b, expected 5 edges diff=0 b=0 z=1",
                     cyc, diff4, borrow4, zero4);
        end
        run4(1, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || {diff4, borrow4, zero4} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rerun_result: got %0d edges diff=%0d b=%b z=%b, expected 5 edges diff=0 b=0 z=1",
                     cyc, diff4, borrow4, zero4);
        end
        n_checks++;
        if (bc !== 4 || dl !== 4) begin
            n_fail++;
            $display("FAIL rerun_handshake: got busy_cycles=%0d done_low=%0d, expected 4 and 4", bc, dl);
        end
    endtask

    task automatic test_load_priority();
        int cyc, bc, dl;
        load_op4(4'd0, 4'd15);
        a4 = 4'd9; b4 = 4'd3; load4 = 1'b1; start4 = 1'b1;
        tick();
        load4 = 1'b0; start4 = 1'b0;
        tick();
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_wins: got busy=%b done=%b, expected busy=0 done=0", busy4, done4);
        end
        a4 = 4'd1; b4 = 4'd1;
        run4(1, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || {diff4, borrow4, zero4} !== {4'd6, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL load_prio_9_3: got %0d edges diff=%0d b=%b z=%b, expected 5 edges diff=6 b=0 z=0",
                     cyc, diff4, borrow4, zero4);
        end
    endtask

    task automatic test_reset_mid_sub();
        int cyc, bc, dl;
        load_op4(4'd7, 4'd9);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_sub_busy: got busy=%b, expected 1", busy4);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({diff4, borrow4, zero4, busy4, done4} !== 8'h00) begin
            n_fail++;
            $display("FAIL async_reset: got diff=%0d b=%b z=%b busy=%b done=%b, expected all 0",
                     diff4, borrow4, zero4, busy4, done4);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run4(1, cyc, bc, dl);
        n_checks++;
        if (cyc !== 5 || {diff4, borrow4, zero4} !== {4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_run: got %0d edges diff=%0d b=%b z=%b, expected 5 edges diff=0 b=0 z=1",
                     cyc, diff4, borrow4, zero4);
        end
    endtask

    task automatic test_width8();
        logic [7:0] va [2] = '{8'd200, 8'd56};
        logic [7:0] vb [2] = '{8'd56, 8'd200};
        logic [7:0] vd [2] = '{8'd144, 8'd112};
        logic       vbr [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int cyc;
            a8 = va[i]; b8 = vb[i]; load8 = 1'b1;
            tick();
            load8 = 1'b0;
            start8 = 1'b1;
            cyc = 0;
            while (cyc < 30) begin
                tick();
                cyc++;
                start8 = 1'b0;
                if (done8) break;
            end
            n_checks++;
            if (cyc !== 9 || {diff8, borrow8, zero8} !== {vd[i], vbr[i], 1'b0}) begin
                n_fail++;
                $display("FAIL width8_%0d: got %0d edges diff=%0d b=%b z=%b, expected 9 edges diff=%0d b=%b z=0",
                         i, cyc, diff8, borrow8, zero8, vd[i], vbr[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_zero_rerun();
        test_load_priority();
        test_reset_mid_sub();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
